// File: rtl/cfo_estimator.sv
// Carrier frequency offset estimator. Autocorrelates the incoming I/Q stream
// against a copy delayed by 2^LAG_LOG2 samples over ACC_LEN products, then
// takes the angle of the sum with a serial CORDIC (vectoring mode). It reports
// the angle divided by the lag as a per-sample phase increment, with
// LSB = pi/2^17 rad.
// Optional build macro: CFOE_ROUND_EN. When it is defined, the final divide by
// the lag rounds half up. When it is undefined, the divide floors.
module cfo_estimator #(
  parameter int ACC_LEN  = 128,
  parameter int LAG_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] di_re,
  input  logic signed [11:0] di_im,
  input  logic               cs_start,
  output logic signed [17:0] cfo_estimated,
  output logic               cfo_estimated_vld,
  output logic               busy
);

  localparam int DATA_W = 12;
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int ACC_W  = 32;
  localparam int CRD_W  = 34;
  localparam int ANG_W  = 20;
  localparam int LAG    = 1 << LAG_LOG2;
  localparam int CNT_W  = $clog2(ACC_LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, CORDIC, DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] dl_re [LAG];
  logic signed [DATA_W-1:0] dl_im [LAG];

  logic signed [2*DATA_W-1:0] m_ac, m_bd, m_bc, m_ad;
  logic signed [PROD_W-1:0]   prod_re_p0, prod_im_p0;
  logic signed [ACC_W-1:0]    acc_re_p1, acc_im_p1;
  logic [CNT_W-1:0]           acc_cnt;

  logic signed [CRD_W-1:0] x_p2, y_p2, x_nx, y_nx, x_sh, y_sh;
  logic signed [ANG_W-1:0] z_p2, z_nx;
  logic [4:0]              cord_cnt;
  logic [3:0]              iter;
  logic                    zero_p2;

  // arctan(2^-i) expressed in pi/2^17 units
  function automatic logic signed [ANG_W-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 20'sd32768;
      4'd1:    return 20'sd19344;
      4'd2:    return 20'sd10221;
      4'd3:    return 20'sd5188;
      4'd4:    return 20'sd2604;
      4'd5:    return 20'sd1303;
      4'd6:    return 20'sd652;
      4'd7:    return 20'sd326;
      4'd8:    return 20'sd163;
      4'd9:    return 20'sd81;
      4'd10:   return 20'sd41;
      4'd11:   return 20'sd20;
      4'd12:   return 20'sd10;
      4'd13:   return 20'sd5;
      4'd14:   return 20'sd3;
      default: return 20'sd1;
    endcase
  endfunction

  // +pi and above clamp to the largest positive code; -pi itself is representable
  function automatic logic signed [17:0] sat_angle(input logic signed [ANG_W-1:0] z);
    if (z > 20'sd131071)
      return 18'sd131071;
    else if (z < -20'sd131072)
      return 18'sh20000;
    else
      return z[17:0];
  endfunction

  // Divide the lag-wide phase by the lag to obtain the per-sample increment
  function automatic logic signed [17:0] scale_angle(input logic signed [17:0] a);
    logic signed [18:0] t;
    t = 19'(a);
`ifdef CFOE_ROUND_EN
    t = t + 19'(1 << (LAG_LOG2 - 1));
`endif
    t = t >>> LAG_LOG2;
    return t[17:0];
  endfunction

  // Delay line runs every cycle, independent of the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAG; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else begin
      dl_re[0] <= di_re;
      dl_im[0] <= di_im;
      for (int i = 1; i < LAG; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  // Stage p0: x * conj(x_d) at full precision
  assign m_ac = 24'(di_re) * 24'(dl_re[LAG-1]);
  assign m_bd = 24'(di_im) * 24'(dl_im[LAG-1]);
  assign m_bc = 24'(di_im) * 24'(dl_re[LAG-1]);
  assign m_ad = 24'(di_re) * 24'(dl_im[LAG-1]);

  // Register the product so the cs_start-cycle sample enters the sum on the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_re_p0 <= '0;
      prod_im_p0 <= '0;
    end else begin
      prod_re_p0 <= PROD_W'(m_ac) + PROD_W'(m_bd);
      prod_im_p0 <= PROD_W'(m_bc) - PROD_W'(m_ad);
    end
  end

  // Stage p1: accumulate ACC_LEN products; wrap-around is harmless at these widths
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re_p1 <= '0;
      acc_im_p1 <= '0;
      acc_cnt   <= '0;
    end else if (cs_start) begin
      acc_re_p1 <= '0;
      acc_im_p1 <= '0;
      acc_cnt   <= '0;
    end else if (state_q == ACCUM) begin
      acc_re_p1 <= acc_re_p1 + ACC_W'(prod_re_p0);
      acc_im_p1 <= acc_im_p1 + ACC_W'(prod_im_p0);
      acc_cnt   <= acc_cnt + 1'b1;
    end
  end

  // One CORDIC vectoring micro-rotation; steer y towards zero
  always_comb begin
    iter = 4'(cord_cnt - 5'd1);
    x_sh = x_p2 >>> iter;
    y_sh = y_p2 >>> iter;
    x_nx = x_p2;
    y_nx = y_p2;
    z_nx = z_p2;
    if (y_p2 >= 0) begin
      x_nx = x_p2 + y_sh;
      y_nx = y_p2 - x_sh;
      z_nx = z_p2 + atan_lut(iter);
    end else begin
      x_nx = x_p2 - y_sh;
      y_nx = y_p2 + x_sh;
      z_nx = z_p2 - atan_lut(iter);
    end
  end

  // Stage p2: cycle 0 folds the left half-plane onto the right, cycles 1..16 iterate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p2     <= '0;
      y_p2     <= '0;
      z_p2     <= '0;
      zero_p2  <= 1'b0;
      cord_cnt <= '0;
    end else if (cs_start) begin
      cord_cnt <= '0;
    end else if (state_q == CORDIC) begin
      cord_cnt <= cord_cnt + 5'd1;
      if (cord_cnt == 5'd0) begin
        zero_p2 <= (acc_re_p1 == 0) && (acc_im_p1 == 0);
        if (acc_re_p1 < 0) begin
          x_p2 <= -CRD_W'(acc_re_p1);
          y_p2 <= -CRD_W'(acc_im_p1);
          z_p2 <= (acc_im_p1 < 0) ? -20'sd131072 : 20'sd131072;
        end else begin
          x_p2 <= CRD_W'(acc_re_p1);
          y_p2 <= CRD_W'(acc_im_p1);
          z_p2 <= '0;
        end
      end else if (cord_cnt <= 5'd16) begin
        x_p2 <= x_nx;
        y_p2 <= y_nx;
        z_p2 <= z_nx;
      end
    end
  end

  // Output register: load on entry to DONE, drop valid on any restart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfo_estimated     <= '0;
      cfo_estimated_vld <= 1'b0;
    end else if (cs_start) begin
      cfo_estimated_vld <= 1'b0;
    end else if (state_q == CORDIC && cord_cnt == 5'd17) begin
      cfo_estimated     <= zero_p2 ? 18'sd0 : scale_angle(sat_angle(z_p2));
      cfo_estimated_vld <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state: cs_start restarts from any state
  always_comb begin
    state_d = state_q;
    if (cs_start) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (acc_cnt == CNT_W'(ACC_LEN - 1)) state_d = CORDIC;
        CORDIC:  if (cord_cnt == 5'd17) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  assign busy = (state_q == ACCUM) || (state_q == CORDIC);

endmodule

// File: tb/tb_cfo_estimator.sv
// Directed testbench for cfo_estimator: rotating tones, zero input, restarts
// and reset abort. Expected estimates come from ideal tone values and from a
// bit-true angle model built from the samples the bench drives.
module tb_cfo_estimator;

  localparam int ACC_LEN  = 128;
  localparam int LAG_LOG2 = 4;
  localparam int LAG      = 16;
  localparam int LAT      = ACC_LEN + 18;
  localparam real PI      = 3.14159265358979323846;
  localparam int ATAN [16] = '{32768, 19344, 10221, 5188, 2604, 1303, 652, 326,
                               163, 81, 41, 20, 10, 5, 3, 1};

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] di_re, di_im;
  logic               cs_start;
  logic signed [17:0] cfo_estimated;
  logic               cfo_estimated_vld;
  logic               busy;

  int  checks = 0;
  int  errors = 0;
  int  hre [8192];
  int  him [8192];
  int  n;
  real w, amp;
  int  last_exp;

  always #5 clk = ~clk;

  cfo_estimator #(.ACC_LEN(ACC_LEN), .LAG_LOG2(LAG_LOG2)) dut (
    .clk(clk),
    .rst(rst),
    .di_re(di_re),
    .di_im(di_im),
    .cs_start(cs_start),
    .cfo_estimated(cfo_estimated),
    .cfo_estimated_vld(cfo_estimated_vld),
    .busy(busy)
  );

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Bit-true angle of the correlation over samples c .. c+ACC_LEN-1
  function automatic int model_angle(input int c);
    longint sre, sim, x, y, dx, dy;
    int are, aim, z, a, b, cr, ci;
    sre = 0;
    sim = 0;
    for (int m = c; m < c + ACC_LEN; m++) begin
      a  = hre[m];
      b  = him[m];
      cr = (m >= LAG) ? hre[m-LAG] : 0;
      ci = (m >= LAG) ? him[m-LAG] : 0;
      sre += longint'(a * cr + b * ci);
      sim += longint'(b * cr - a * ci);
    end
    are = int'(sre);
    aim = int'(sim);
    if (are == 0 && aim == 0) return 0;
    x = are;
    y = aim;
    z = 0;
    if (are < 0) begin
      x = -x;
      y = -y;
      z = (aim >= 0) ? 131072 : -131072;
    end
    for (int i = 0; i < 16; i++) begin
      dx = y >>> i;
      dy = x >>> i;
      if (y >= 0) begin
        x = x + dx; y = y - dy; z = z + ATAN[i];
      end else begin
        x = x - dx; y = y + dy; z = z - ATAN[i];
      end
    end
    if (z > 131071) z = 131071;
    if (z < -131072) z = -131072;
    return z;
  endfunction

  function automatic int model_cfo(input int c);
    int z;
    z = model_angle(c);
`ifdef CFOE_ROUND_EN
    return (z + 8) >>> LAG_LOG2;
`else
    return z >>> LAG_LOG2;
`endif
  endfunction

  task automatic drive_cycle(input logic cs);
    real ph;
    ph = w * n;
    hre[n] = rnd(amp * $cos(ph));
    him[n] = rnd(amp * $sin(ph));
    di_re = 12'(hre[n]);
    di_im = 12'(him[n]);
    cs_start = cs;
    @(posedge clk);
    #1;
    cs_start = 1'b0;
    n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cs_start = 1'b0;
    di_re = '0;
    di_im = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
  endtask

  // Runs one estimate from cs_start and checks latency and the model value
  task automatic run_estimate(input string tag, output int got, output int expv);
    int c;
    c = n;
    drive_cycle(1'b1);
    repeat (LAT - 1) drive_cycle(1'b0);
    checks++;
    if (cfo_estimated_vld !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_early: vld=%b busy=%b at +%0d, required vld=0 busy=1", tag, cfo_estimated_vld, busy, LAT - 1);
    end
    drive_cycle(1'b0);
    checks++;
    if (cfo_estimated_vld !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_vld: vld=%b busy=%b at +%0d, required vld=1 busy=0", tag, cfo_estimated_vld, busy, LAT);
    end
    expv = model_cfo(c);
    got = int'(cfo_estimated);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s_model: cfo=%0d, required %0d", tag, got, expv);
    end
    last_exp = expv;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cfo_estimated !== 18'sd0) begin
      errors++;
      $display("FAIL reset_cfo: got %0d, required 0", cfo_estimated);
    end
    checks++;
    if (cfo_estimated_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld: got %b, required 0", cfo_estimated_vld);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_tone_pos();
    int got, expv;
    amp = 1000.0;
    w = PI / 32.0;
    repeat (200) drive_cycle(1'b0);
    run_estimate("tone_pos", got, expv);
    checks++;
    if (got < 4095 || got > 4097) begin
      errors++;
      $display("FAIL tone_pos_ideal: cfo=%0d, required 4096+/-1", got);
    end
  endtask

  task automatic test_back_to_back();
    int c2, bad_busy, bad_vld, got, expv;
    // Restart from DONE: valid drops, value stays
    drive_cycle(1'b1);
    checks++;
    if (cfo_estimated_vld !== 1'b0 || int'(cfo_estimated) !== last_exp) begin
      errors++;
      $display("FAIL restart_hold: vld=%b cfo=%0d, required vld=0 cfo=%0d", cfo_estimated_vld, cfo_estimated, last_exp);
    end
    bad_busy = 0;
    bad_vld = 0;
    repeat (49) begin
      drive_cycle(1'b0);
      if (busy !== 1'b1) bad_busy++;
      if (cfo_estimated_vld !== 1'b0) bad_vld++;
    end
    c2 = n;
    drive_cycle(1'b1);
    repeat (LAT - 1) begin
      if (busy !== 1'b1) bad_busy++;
      if (cfo_estimated_vld !== 1'b0) bad_vld++;
      drive_cycle(1'b0);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL restart_busy: %0d cycles with busy low, required 0", bad_busy);
    end
    checks++;
    if (bad_vld != 0 || cfo_estimated_vld !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_vld: %0d early valid cycles, required 0", bad_vld);
    end
    drive_cycle(1'b0);
    checks++;
    if (cfo_estimated_vld !== 1'b1) begin
      errors++;
      $display("FAIL restart_vld: got %b at second start +%0d, required 1", cfo_estimated_vld, LAT);
    end
    expv = model_cfo(c2);
    got = int'(cfo_estimated);
    last_exp = expv;
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL restart_model: cfo=%0d, required %0d", got, expv);
    end
  endtask

  task automatic test_tone_neg();
    int got, expv, bad;
    amp = 1000.0;
    w = -84.0 * PI / 131072.0;
    repeat (30) drive_cycle(1'b0);
    run_estimate("tone_neg", got, expv);
    checks++;
    if (got < -85 || got > -83) begin
      errors++;
      $display("FAIL tone_neg_ideal: cfo=%0d, required -84 (18'h3FFAC) +/-1", got);
    end
    bad = 0;
    repeat (40) begin
      drive_cycle(1'b0);
      if (cfo_estimated_vld !== 1'b1 || int'(cfo_estimated) !== expv) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tone_neg_hold: %0d cycles lost the estimate, required 0", bad);
    end
  endtask

  task automatic test_zero();
    int got, expv;
    amp = 0.0;
    w = 0.0;
    repeat (30) drive_cycle(1'b0);
    run_estimate("zero", got, expv);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL zero_value: cfo=%0d, required 0", got);
    end
  endtask

  task automatic test_round();
    int got, expv;
    amp = 1000.0;
    w = -62.5 * PI / 131072.0;
    repeat (30) drive_cycle(1'b0);
    run_estimate("round", got, expv);
    checks++;
    if (got < -63 || got > -62) begin
      errors++;
      $display("FAIL round_ideal: cfo=%0d, required -63..-62", got);
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    amp = 1000.0;
    w = PI / 32.0;
    repeat (20) drive_cycle(1'b0);
    drive_cycle(1'b1);
    repeat (134) drive_cycle(1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (cfo_estimated !== 18'sd0 || cfo_estimated_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: cfo=%0d vld=%b busy=%b, required 0/0/0", cfo_estimated, cfo_estimated_vld, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    bad = 0;
    repeat (200) begin
      drive_cycle(1'b0);
      if (cfo_estimated_vld !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_no_vld: %0d cycles with vld/busy high, required 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    cs_start = 1'b0;
    di_re = '0;
    di_im = '0;
    n = 0;
    w = 0.0;
    amp = 0.0;
    last_exp = 0;
    test_reset();
    test_tone_pos();
    test_back_to_back();
    test_tone_neg();
    test_zero();
    test_round();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
